// File: rtl/buffer_interconnect_radix.sv
// Radix-R pipelined crossbar between buffer-RAM slots and FHE ALU modules.
// Each destination owns its own mux tree; a valid bit and out-of-range select detection travel with every route.
package buffer_interconnect_radix_pkg;
  localparam int E          = 8;
  localparam int FSIZE      = 64;
  localparam int SLOT_NUM   = 20;
  localparam int MODULE_NUM = 20;
  localparam int ADDR_W     = 9;

  typedef struct packed {
    logic                  wren;
    logic [ADDR_W-1:0]     waddr;
    logic [E*FSIZE-1:0]    wdata;
  } BufferRAMTEFsizeInputs;
endpackage

module buffer_interconnect_radix_route #(
  parameter int N_SRC = 20,
  parameter int N_DST = 20,
  parameter int SW    = 5,
  parameter int BR    = 3,
  parameter int ST    = 2,
  parameter int DW    = 512
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic [N_DST-1:0][SW-1:0]   sel,
  input  logic [N_DST-1:0]           sel_vld,
  input  logic [N_SRC-1:0][DW-1:0]   src,
  output logic [N_DST-1:0][DW-1:0]   dst,
  output logic [N_DST-1:0]           dst_vld,
  output logic                       bad_sel
);
  localparam int RADIX  = 1 << BR;
  localparam int LEAVES = RADIX ** ST;
  localparam int SELP   = BR * ST;
  localparam logic [SW:0] SRC_LIMIT = N_SRC[SW:0];

  logic [N_SRC-1:0][DW-1:0]  src_q;
  logic [LEAVES-1:0][DW-1:0] leaves;
  logic [N_DST-1:0]          sel_ok;

  // One shared capture of the sources feeds every destination's first stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   src_q <= '0;
    else if (en) src_q <= src;
  end

  always_comb begin
    leaves              = '0;
    leaves[N_SRC-1:0]   = src_q;
  end

  assign bad_sel = en & |(sel_vld & ~sel_ok);

  for (genvar d = 0; d < N_DST; d++) begin : g_dst
    logic [SELP-1:0] sel_pad;

    assign sel_ok[d] = ({1'b0, sel[d]} < SRC_LIMIT);

    always_comb begin
      sel_pad          = '0;
      sel_pad[SW-1:0]  = sel[d];
    end

    for (genvar k = 0; k < ST; k++) begin : g_st
      localparam int OUT_N = RADIX ** (ST - k - 1);
      localparam int RSW   = BR * (ST - k);

      logic [OUT_N-1:0][RADIX-1:0][DW-1:0] din;
      logic [OUT_N-1:0][DW-1:0]            dout;
      logic [RSW-1:0]                      sel_r;
      logic                                vld_r;

      if (k == 0) begin : g_cap
        assign din = leaves;
        // A bad select is captured as an idle route so it can never reach a destination.
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            sel_r <= '0;
            vld_r <= 1'b0;
          end else if (en) begin
            sel_r <= sel_ok[d] ? sel_pad : '0;
            vld_r <= sel_vld[d] & sel_ok[d];
          end
        end
      end else begin : g_fwd
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            din   <= '0;
            sel_r <= '0;
            vld_r <= 1'b0;
          end else if (en) begin
            din   <= g_st[k-1].dout;
            sel_r <= g_st[k-1].sel_r[RSW+BR-1:BR];
            vld_r <= g_st[k-1].vld_r;
          end
        end
      end

      for (genvar g = 0; g < OUT_N; g++) begin : g_mux
        assign dout[g] = din[g][sel_r[BR-1:0]];
      end
    end

    assign dst[d]     = g_st[ST-1].vld_r ? g_st[ST-1].dout[0] : '0;
    assign dst_vld[d] = g_st[ST-1].vld_r;
  end
endmodule

module buffer_interconnect_radix
  import buffer_interconnect_radix_pkg::*;
#(
  parameter int SLOT_N = SLOT_NUM,
  parameter int MOD_N  = MODULE_NUM,
  parameter int RADIX  = 8,
  parameter int W      = E * FSIZE
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 en,
  input  logic [SLOT_N-1:0][$clog2(MOD_N)-1:0] module_select,
  input  logic [SLOT_N-1:0]                    msel_vld,
  input  logic [MOD_N-1:0][$clog2(SLOT_N)-1:0] slot_select,
  input  logic [MOD_N-1:0]                     ssel_vld,
  input  BufferRAMTEFsizeInputs [MOD_N-1:0]    module_outputs,
  input  logic [SLOT_N-1:0][W-1:0]             ram_outputs,
  output BufferRAMTEFsizeInputs [SLOT_N-1:0]   ram_inputs,
  output logic [SLOT_N-1:0]                    ram_inputs_vld,
  output logic [MOD_N-1:0][W-1:0]              module_inputs,
  output logic [MOD_N-1:0]                     module_inputs_vld,
  output logic [1:0]                           sel_err,
  input  logic                                 err_clr
);
  localparam int MSW  = $clog2(MOD_N);
  localparam int SSW  = $clog2(SLOT_N);
  localparam int BR   = $clog2(RADIX);
  localparam int ST_M = (MSW + BR - 1) / BR;
  localparam int ST_S = (SSW + BR - 1) / BR;
  localparam int BW   = $bits(BufferRAMTEFsizeInputs);

  logic [MOD_N-1:0][BW-1:0]  mod_bits;
  logic [SLOT_N-1:0][BW-1:0] ram_bits;
  logic                      m_bad;
  logic                      s_bad;

  assign mod_bits   = module_outputs;
  assign ram_inputs = ram_bits;

  buffer_interconnect_radix_route #(
    .N_SRC(MOD_N), .N_DST(SLOT_N), .SW(MSW), .BR(BR), .ST(ST_M), .DW(BW)
  ) u_to_slot (
    .clk(clk), .rstn(rstn), .en(en),
    .sel(module_select), .sel_vld(msel_vld), .src(mod_bits),
    .dst(ram_bits), .dst_vld(ram_inputs_vld), .bad_sel(m_bad)
  );

  buffer_interconnect_radix_route #(
    .N_SRC(SLOT_N), .N_DST(MOD_N), .SW(SSW), .BR(BR), .ST(ST_S), .DW(W)
  ) u_to_module (
    .clk(clk), .rstn(rstn), .en(en),
    .sel(slot_select), .sel_vld(ssel_vld), .src(ram_outputs),
    .dst(module_inputs), .dst_vld(module_inputs_vld), .bad_sel(s_bad)
  );

  // A new error in the same cycle as err_clr must survive the clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sel_err <= 2'b00;
    else       sel_err <= (err_clr ? 2'b00 : sel_err) | {s_bad, m_bad};
  end
endmodule
